// File: rtl/mindy_out_arb.sv
// Packet-level arbiter that merges the mindy metadata (MD) and frame-data (FD) AXI streams onto one output.
// Optional statistics counters are built when MINDY_ARB_STATS_EN is defined.
module mindy_out_arb #(
  parameter int unsigned DATA_WBITS     = 512,
  parameter int unsigned MD_BEATS       = 2,
  parameter int unsigned FD_BURST_BEATS = 64,
  parameter int unsigned MD_STREAK_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WBITS-1:0] AXIS_MD_TDATA,
  input  logic                  AXIS_MD_TVALID,
  output logic                  AXIS_MD_TREADY,
  input  logic [DATA_WBITS-1:0] AXIS_FD_TDATA,
  input  logic                  AXIS_FD_TVALID,
  output logic                  AXIS_FD_TREADY,
  output logic [DATA_WBITS-1:0] AXIS_OUT_TDATA,
  output logic                  AXIS_OUT_TVALID,
  input  logic                  AXIS_OUT_TREADY,
  output logic                  AXIS_OUT_TLAST,
  output logic                  AXIS_OUT_TUSER,
  input  logic [31:0]           FRAME_SIZE
`ifdef MINDY_ARB_STATS_EN
  ,
  output logic [31:0]           STAT_MD_PKTS,
  output logic [31:0]           STAT_FD_PKTS,
  output logic [31:0]           STAT_FRAMES
`endif
);

  localparam int unsigned BPB      = DATA_WBITS / 8;
  localparam int unsigned MAX_PKT  = (MD_BEATS > FD_BURST_BEATS) ? MD_BEATS : FD_BURST_BEATS;
  localparam int unsigned CNT_W    = $clog2(MAX_PKT + 1);
  localparam int unsigned STREAK_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MD   = 2'd1;
  localparam logic [1:0] S_FD   = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [CNT_W-1:0]    beat_cnt;
  logic [CNT_W-1:0]    pkt_beats;
  logic [CNT_W-1:0]    fd_pkt_beats;
  logic [STREAK_W-1:0] md_streak;
  logic [31:0]         frame_beats;
  logic [31:0]         fd_rem;
  logic [31:0]         fd_rem_eff;
  logic [31:0]         size_beats;
  logic [31:0]         fd_start;
  logic                hs;
  logic                last_c;
  logic                last_hs;
  logic                fd_beat;
  logic                new_frame;
  logic                fd_ok;
  logic                arb_md;
  logic                arb_fd;
  logic                grant;

  // Handshake derived from inputs and state only, keeping the mux free of loops
  always_comb begin
    hs = 1'b0;
    case (state)
      S_MD:    hs = AXIS_MD_TVALID & AXIS_OUT_TREADY;
      S_FD:    hs = AXIS_FD_TVALID & AXIS_OUT_TREADY;
      default: hs = 1'b0;
    endcase
  end

  assign last_c  = (beat_cnt == (pkt_beats - CNT_W'(1)));
  assign last_hs = hs & last_c;
  assign fd_beat = (state == S_FD) & hs;

  // fd_rem as it stands after this cycle's beat; zero means the next FD grant opens a frame
  assign size_beats = FRAME_SIZE / 32'(BPB);
  assign fd_rem_eff = fd_beat ? (fd_rem - 32'd1) : fd_rem;
  assign new_frame  = (fd_rem_eff == 32'd0);
  assign fd_ok      = AXIS_FD_TVALID & (new_frame ? (size_beats != 32'd0) : (frame_beats != 32'd0));
  assign fd_start   = new_frame ? size_beats : fd_rem_eff;
  assign fd_pkt_beats = (fd_start >= 32'(FD_BURST_BEATS)) ? CNT_W'(FD_BURST_BEATS) : CNT_W'(fd_start);

  assign arb_md = AXIS_MD_TVALID & (~fd_ok | (md_streak < STREAK_W'(MD_STREAK_MAX)));
  assign arb_fd = ~arb_md & fd_ok;
  assign grant  = (state == S_IDLE) | last_hs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (grant) begin
      if (arb_md)      state_nxt = S_MD;
      else if (arb_fd) state_nxt = S_FD;
      else             state_nxt = S_IDLE;
    end
  end

  // Zero-latency output mux onto the granted stream
  always_comb begin
    AXIS_OUT_TDATA  = '0;
    AXIS_OUT_TVALID = 1'b0;
    AXIS_OUT_TLAST  = 1'b0;
    AXIS_OUT_TUSER  = 1'b0;
    AXIS_MD_TREADY  = 1'b0;
    AXIS_FD_TREADY  = 1'b0;
    case (state)
      S_MD: begin
        AXIS_OUT_TDATA  = AXIS_MD_TDATA;
        AXIS_OUT_TVALID = AXIS_MD_TVALID;
        AXIS_OUT_TLAST  = last_c;
        AXIS_OUT_TUSER  = 1'b1;
        AXIS_MD_TREADY  = AXIS_OUT_TREADY;
      end
      S_FD: begin
        AXIS_OUT_TDATA  = AXIS_FD_TDATA;
        AXIS_OUT_TVALID = AXIS_FD_TVALID;
        AXIS_OUT_TLAST  = last_c;
        AXIS_FD_TREADY  = AXIS_OUT_TREADY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt    <= '0;
      pkt_beats   <= '0;
      md_streak   <= '0;
      frame_beats <= '0;
      fd_rem      <= '0;
    end else begin
      fd_rem <= fd_rem_eff;
      if (grant) begin
        beat_cnt <= '0;
        if (arb_md) begin
          pkt_beats <= CNT_W'(MD_BEATS);
          if (!AXIS_FD_TVALID)               md_streak <= '0;
          else if (md_streak != '1)          md_streak <= md_streak + STREAK_W'(1);
        end else if (arb_fd) begin
          pkt_beats <= fd_pkt_beats;
          md_streak <= '0;
          if (new_frame) begin
            frame_beats <= size_beats;
            fd_rem      <= size_beats;
          end
        end
      end else if (hs) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

`ifdef MINDY_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      STAT_MD_PKTS <= '0;
      STAT_FD_PKTS <= '0;
      STAT_FRAMES  <= '0;
    end else begin
      if (last_hs && state == S_MD) STAT_MD_PKTS <= STAT_MD_PKTS + 32'd1;
      if (last_hs && state == S_FD) STAT_FD_PKTS <= STAT_FD_PKTS + 32'd1;
      if (fd_beat && fd_rem == 32'd1) STAT_FRAMES <= STAT_FRAMES + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mindy_out_arb.sv
// Randomized bench for mindy_out_arb: packet/frame reference model plus per-stream ordering scoreboard.
module tb_mindy_out_arb;
  localparam int unsigned W = 512;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] AXIS_MD_TDATA, AXIS_FD_TDATA, AXIS_OUT_TDATA;
  logic         AXIS_MD_TVALID, AXIS_MD_TREADY, AXIS_FD_TVALID, AXIS_FD_TREADY;
  logic         AXIS_OUT_TVALID, AXIS_OUT_TREADY, AXIS_OUT_TLAST, AXIS_OUT_TUSER;
  logic [31:0]  FRAME_SIZE;

  always #5 clk = ~clk;

  mindy_out_arb dut (
    .clk(clk), .reset(reset),
    .AXIS_MD_TDATA(AXIS_MD_TDATA), .AXIS_MD_TVALID(AXIS_MD_TVALID), .AXIS_MD_TREADY(AXIS_MD_TREADY),
    .AXIS_FD_TDATA(AXIS_FD_TDATA), .AXIS_FD_TVALID(AXIS_FD_TVALID), .AXIS_FD_TREADY(AXIS_FD_TREADY),
    .AXIS_OUT_TDATA(AXIS_OUT_TDATA), .AXIS_OUT_TVALID(AXIS_OUT_TVALID), .AXIS_OUT_TREADY(AXIS_OUT_TREADY),
    .AXIS_OUT_TLAST(AXIS_OUT_TLAST), .AXIS_OUT_TUSER(AXIS_OUT_TUSER), .FRAME_SIZE(FRAME_SIZE)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Source state
  bit          md_en, fd_en;
  int unsigned md_prob, fd_prob, rdy_prob;
  int          md_seq = 0, fd_seq = 0;
  bit          md_hs, fd_hs;

  // Reference model state
  int beat_idx, pkt_len, fd_pos, frame_len, cyc, first_beat, out_beats, md_pkts, fd_pkts;
  bit pkt_user, no_fd_chk;
  int exp_seq [2];
  int len_q [$];
  bit user_q [$];

  function automatic logic [W-1:0] mk(input bit user, input int seq);
    logic [W-1:0] d;
    d = '0;
    d[W-1 -: 8]  = user ? 8'hAD : 8'hFD;
    d[31:0]      = 32'(seq);
    d[287:256]   = ~32'(seq);
    return d;
  endfunction

  task automatic src_update();
    if (md_hs) md_seq++;
    if (fd_hs) fd_seq++;
    if (md_hs || !AXIS_MD_TVALID) AXIS_MD_TVALID = md_en && ($urandom_range(99) < md_prob);
    if (fd_hs || !AXIS_FD_TVALID) AXIS_FD_TVALID = fd_en && ($urandom_range(99) < fd_prob);
    AXIS_MD_TDATA   = mk(1'b1, md_seq);
    AXIS_FD_TDATA   = mk(1'b0, fd_seq);
    AXIS_OUT_TREADY = ($urandom_range(99) < rdy_prob);
  endtask

  // Packet model: MD packets are 2 beats; FD packets are min(64, remaining beats in frame)
  task automatic monitor();
    bit hs, u, exp_last;
    if (reset) begin
      chk("reset_outs", W'({AXIS_OUT_TVALID, AXIS_OUT_TLAST, AXIS_OUT_TUSER, AXIS_MD_TREADY, AXIS_FD_TREADY}), '0);
      beat_idx = 0; fd_pos = 0; cyc = 0; first_beat = -1;
      md_hs = 1'b0; fd_hs = 1'b0;
      return;
    end
    md_hs = AXIS_MD_TVALID & AXIS_MD_TREADY;
    fd_hs = AXIS_FD_TVALID & AXIS_FD_TREADY;
    if (no_fd_chk) chk("fd_tready_blocked", W'(AXIS_FD_TREADY), '0);
    hs = AXIS_OUT_TVALID & AXIS_OUT_TREADY;
    if (hs) begin
      u = AXIS_OUT_TUSER;
      if (first_beat < 0) first_beat = cyc;
      out_beats++;
      if (beat_idx == 0) begin
        pkt_user = u;
        if (u) pkt_len = 2;
        else begin
          if (fd_pos == 0) frame_len = int'(FRAME_SIZE / 32'd64);
          if (frame_len == 0) begin
            chk("fd_granted_on_empty_frame", W'(u), W'(1));
            frame_len = 1;
          end
          pkt_len = (frame_len - fd_pos > 64) ? 64 : frame_len - fd_pos;
        end
      end else begin
        chk("no_interleave", W'(u), W'(pkt_user));
      end
      chk("data_order", AXIS_OUT_TDATA, mk(u, exp_seq[u]));
      exp_seq[u]++;
      exp_last = (beat_idx == pkt_len - 1);
      chk("tlast", W'(AXIS_OUT_TLAST), W'(exp_last));
      if (!u) begin
        fd_pos++;
        if (fd_pos >= frame_len) fd_pos = 0;
      end
      if (exp_last) begin
        len_q.push_back(pkt_len);
        user_q.push_back(u);
        if (u) md_pkts++; else fd_pkts++;
        beat_idx = 0;
      end else begin
        beat_idx++;
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    src_update();
  endtask

  task automatic clear_log();
    len_q.delete(); user_q.delete();
    md_pkts = 0; fd_pkts = 0; out_beats = 0;
  endtask

  task automatic start_test(input logic [31:0] fs, input bit men, input bit fen,
                            input int unsigned mp, input int unsigned fp, input int unsigned rp);
    FRAME_SIZE = fs; md_en = men; fd_en = fen; md_prob = mp; fd_prob = fp; rdy_prob = rp;
    reset = 1'b1;
    AXIS_MD_TVALID = md_en && ($urandom_range(99) < md_prob);
    AXIS_FD_TVALID = fd_en && ($urandom_range(99) < fd_prob);
    AXIS_MD_TDATA  = mk(1'b1, md_seq);
    AXIS_FD_TDATA  = mk(1'b0, fd_seq);
    repeat (3) cycle();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic run_until_pkts(input string tag, input int n, input int budget);
    while (len_q.size() < n && budget > 0) begin
      cycle();
      budget--;
    end
    chk({tag, "_pkt_count"}, W'(len_q.size() >= n), W'(1));
  endtask

  task automatic run_until_beats(input string tag, input int n, input int budget);
    while (out_beats < n && budget > 0) begin
      cycle();
      budget--;
    end
    chk({tag, "_beat_count"}, W'(out_beats >= n), W'(1));
  endtask

  task automatic chk_lens(input string tag, input int exp_len [4], input int n);
    for (int i = 0; i < n; i++) begin
      if (i < len_q.size()) begin
        chk($sformatf("%s_len%0d", tag, i), W'(len_q[i]), W'(exp_len[i]));
        chk($sformatf("%s_user%0d", tag, i), W'(user_q[i]), '0);
      end
    end
  endtask

  initial begin
    int lens [4];
    reset = 1'b1; no_fd_chk = 1'b0;
    AXIS_MD_TVALID = 1'b0; AXIS_FD_TVALID = 1'b0; AXIS_OUT_TREADY = 1'b0;
    AXIS_MD_TDATA = '0; AXIS_FD_TDATA = '0; FRAME_SIZE = 32'd8192;
    md_hs = 1'b0; fd_hs = 1'b0;
    exp_seq[0] = 0; exp_seq[1] = 0;
    clear_log();

    // Two 64-beat packets per 8 KiB frame, one idle cycle of grant latency
    start_test(32'd8192, 1'b0, 1'b1, 0, 100, 100);
    run_until_pkts("t1", 2, 400);
    lens = '{64, 64, 0, 0};
    chk_lens("t1", lens, 2);
    chk("t1_first_beat_cycle", W'(first_beat), W'(1));

    // 65-beat frame splits into 64 + 1
    start_test(32'd4160, 1'b0, 1'b1, 0, 100, 100);
    run_until_pkts("t2", 4, 400);
    lens = '{64, 1, 64, 1};
    chk_lens("t2", lens, 4);

    // FRAME_SIZE change mid-frame takes effect only at the next frame
    start_test(32'd4160, 1'b0, 1'b1, 0, 100, 100);
    run_until_beats("t2b", 20, 100);
    FRAME_SIZE = 32'd8192;
    run_until_pkts("t2b", 4, 400);
    lens = '{64, 1, 64, 64};
    chk_lens("t2b", lens, 4);

    // Both streams saturated: four MD packets then one FD packet
    start_test(32'd8192, 1'b1, 1'b1, 100, 100, 100);
    run_until_pkts("t3", 10, 1000);
    for (int i = 0; i < 10 && i < user_q.size(); i++)
      chk($sformatf("t3_grant%0d", i), W'(user_q[i]), W'(i % 5 != 4));

    // Random valid gaps and backpressure
    for (int r = 0; r < 3; r++) begin
      start_test(32'(64 * $urandom_range(150, 1) + $urandom_range(63)), 1'b1, 1'b1, 60, 50, 70);
      repeat (2500) cycle();
      chk($sformatf("t4_%0d_md_flow", r), W'(md_pkts > 0), W'(1));
      chk($sformatf("t4_%0d_fd_flow", r), W'(fd_pkts > 0), W'(1));
    end

    // Frame smaller than one beat: FD blocked, MD unaffected
    start_test(32'd32, 1'b1, 1'b1, 100, 100, 80);
    no_fd_chk = 1'b1;
    repeat (300) cycle();
    no_fd_chk = 1'b0;
    chk("t5_md_flow", W'(md_pkts >= 10), W'(1));
    chk("t5_fd_none", W'(fd_pkts), '0);

    // Reset mid-packet abandons it; the next FD grant opens a fresh frame
    start_test(32'd4160, 1'b0, 1'b1, 0, 100, 100);
    run_until_beats("t6", 10, 100);
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    clear_log();
    run_until_pkts("t6", 1, 200);
    lens = '{64, 0, 0, 0};
    chk_lens("t6", lens, 1);
    chk("t6_first_beat_cycle", W'(first_beat), W'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
